// File: rtl/event_counter_pkg.sv
// event_counter_pkg
// Shared types and constants for the multi-channel event counter:
//   cnt_mode_e     - behaviour at the maximum count (wrap or saturate)
//   *_MIN / *_MAX  - legal ranges for the NUM_CH and WIDTH parameters
//   SYNC_RST_VAL   - reset value of the synchroniser / edge-detect flops
//   rd_ch_width()  - width of the read channel select (at least 1 bit)
package event_counter_pkg;

  typedef enum logic {
    CNT_WRAP     = 1'b0,
    CNT_SATURATE = 1'b1
  } cnt_mode_e;

  localparam int NUM_CH_MIN = 1;
  localparam int NUM_CH_MAX = 16;
  localparam int WIDTH_MIN  = 2;
  localparam int WIDTH_MAX  = 32;

  // Ones, so an input that is already high when reset is released does not
  // look like a fresh rising edge.
  localparam logic SYNC_RST_VAL = 1'b1;

  function automatic int rd_ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/event_channel.sv
// event_channel
// One counting channel: 2-flop synchroniser, rising-edge detect, counter with
// clear / read-clear / increment priority, wrap or saturate at all-ones,
// sticky overflow and a registered threshold-hit pulse.
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   event_in        asynchronous event level
//   hold            drop a detected event while high
//   clear           synchronous clear of count and overflow
//   rd_clr          read-clear strobe, already decoded for this channel
//   threshold       compare value for thresh_hit
//   count           live count
//   overflow        sticky overflow flag
//   thresh_hit      one-cycle pulse when an increment lands on threshold
module event_channel
  import event_counter_pkg::*;
#(
  parameter int        WIDTH = 8,
  parameter cnt_mode_e MODE  = CNT_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             event_in,
  input  logic             hold,
  input  logic             clear,
  input  logic             rd_clr,
  input  logic [WIDTH-1:0] threshold,
  output logic [WIDTH-1:0] count,
  output logic             overflow,
  output logic             thresh_hit
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic             sync1_q, sync2_q, prev_q;
  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             hit_q, hit_d;
  logic             inc;
  logic [WIDTH-1:0] inc_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= SYNC_RST_VAL;
      sync2_q <= SYNC_RST_VAL;
      prev_q  <= SYNC_RST_VAL;
      count_q <= '0;
      ovf_q   <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      sync1_q <= event_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      hit_q   <= hit_d;
    end
  end

  always_comb begin
    inc     = sync2_q & ~prev_q & ~hold;
    // Natural modulo-2^WIDTH add: all-ones rolls to zero for the wrap case.
    inc_val = count_q + WIDTH'(1);
    count_d = count_q;
    ovf_d   = ovf_q;
    hit_d   = 1'b0;
    if (clear) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (rd_clr) begin
      // The read already returned the old count; a coincident event is the
      // first event of the new interval, so it counts as an increment onto 1.
      count_d = inc ? WIDTH'(1) : '0;
      ovf_d   = 1'b0;
      hit_d   = inc && (threshold == WIDTH'(1));
    end else if (inc) begin
      if (count_q == CNT_MAX) begin
        ovf_d = 1'b1;
      end
      if (!(MODE == CNT_SATURATE && count_q == CNT_MAX)) begin
        count_d = inc_val;
        hit_d   = (inc_val == threshold);
      end
    end
  end

  assign count      = count_q;
  assign overflow   = ovf_q;
  assign thresh_hit = hit_q;

endmodule

// File: rtl/multi_event_counter.sv
// multi_event_counter
// NUM_CH independent event counters sharing one clock, a common threshold and
// a registered read port with optional clear-on-read.
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   event_in        per-channel asynchronous event levels
//   hold, clear     per-channel hold and synchronous clear
//   threshold       shared thresh_hit compare value
//   count           live counts, channel i at [i*WIDTH +: WIDTH]
//   overflow        per-channel sticky overflow
//   thresh_hit      per-channel one-cycle threshold pulse
//   rd_req/rd_ch/rd_clr   read request, channel select, clear-on-read
//   rd_valid/rd_data      registered read response, one cycle after rd_req
module multi_event_counter
  import event_counter_pkg::*;
#(
  parameter int        NUM_CH = 4,
  parameter int        WIDTH  = 8,
  parameter cnt_mode_e MODE   = CNT_WRAP,
  localparam int       RD_W   = rd_ch_width(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       event_in,
  input  logic [NUM_CH-1:0]       hold,
  input  logic [NUM_CH-1:0]       clear,
  input  logic [WIDTH-1:0]        threshold,
  output logic [NUM_CH*WIDTH-1:0] count,
  output logic [NUM_CH-1:0]       overflow,
  output logic [NUM_CH-1:0]       thresh_hit,
  input  logic                    rd_req,
  input  logic [RD_W-1:0]         rd_ch,
  input  logic                    rd_clr,
  output logic                    rd_valid,
  output logic [WIDTH-1:0]        rd_data
);

  if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX ||
      WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_cfg
    $error("multi_event_counter: NUM_CH or WIDTH out of range");
  end

  logic [WIDTH-1:0]  cnt_arr [NUM_CH];
  logic [NUM_CH-1:0] rd_clr_vec;
  logic [WIDTH-1:0]  rd_sel;
  logic              rd_valid_q;
  logic [WIDTH-1:0]  rd_data_q;

  // Out-of-range selects match no channel, so they read 0 and clear nothing.
  always_comb begin
    rd_clr_vec = '0;
    rd_sel     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == RD_W'(i)) begin
        rd_sel        = cnt_arr[i];
        rd_clr_vec[i] = rd_req & rd_clr;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    event_channel #(
      .WIDTH (WIDTH),
      .MODE  (MODE)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .event_in   (event_in[g]),
      .hold       (hold[g]),
      .clear      (clear[g]),
      .rd_clr     (rd_clr_vec[g]),
      .threshold  (threshold),
      .count      (cnt_arr[g]),
      .overflow   (overflow[g]),
      .thresh_hit (thresh_hit[g])
    );
    assign count[g*WIDTH +: WIDTH] = cnt_arr[g];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_req;
      rd_data_q  <= rd_req ? rd_sel : '0;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_multi_event_counter.sv
// Randomised scoreboard bench: two DUTs (wrap and saturate, 3 channels of 4
// bits) share one stimulus stream. A reference model predicts the state after
// every edge and the response to every read; a monitor compares.
module tb_multi_event_counter;
  import event_counter_pkg::*;

  localparam int NCH  = 3;
  localparam int W    = 4;
  localparam int MAXC = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   event_in, hold, clear;
  logic [W-1:0]     threshold;
  logic             rd_req, rd_clr;
  logic [1:0]       rd_ch;
  logic [NCH*W-1:0] count_w, count_s;
  logic [NCH-1:0]   ovf_w, ovf_s, hit_w, hit_s;
  logic             rdv_w, rdv_s;
  logic [W-1:0]     rdd_w, rdd_s;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  multi_event_counter #(.NUM_CH(NCH), .WIDTH(W), .MODE(CNT_WRAP)) u_wrap (
    .clk(clk), .rst(rst), .event_in(event_in), .hold(hold), .clear(clear),
    .threshold(threshold), .count(count_w), .overflow(ovf_w),
    .thresh_hit(hit_w), .rd_req(rd_req), .rd_ch(rd_ch), .rd_clr(rd_clr),
    .rd_valid(rdv_w), .rd_data(rdd_w)
  );

  multi_event_counter #(.NUM_CH(NCH), .WIDTH(W), .MODE(CNT_SATURATE)) u_sat (
    .clk(clk), .rst(rst), .event_in(event_in), .hold(hold), .clear(clear),
    .threshold(threshold), .count(count_s), .overflow(ovf_s),
    .thresh_hit(hit_s), .rd_req(rd_req), .rd_ch(rd_ch), .rd_clr(rd_clr),
    .rd_valid(rdv_s), .rd_data(rdd_s)
  );

  typedef struct packed {
    logic [NCH*W-1:0] cw, cs;
    logic [NCH-1:0]   ow, os, hw, hs;
  } st_t;

  typedef struct packed {
    logic [W-1:0] dw, ds;
  } rd_t;

  st_t stq[$];
  rd_t rdq[$];

  // Model: index 0 = wrap DUT, 1 = saturate DUT.
  int m_cnt [2][NCH];
  bit m_ovf [2][NCH];
  bit m_hit [2][NCH];
  // Samples of event_in taken at successive edges, newest at [0].
  bit hist  [NCH][4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < 4; k++) hist[c][k] = 1'b1;
      for (int m = 0; m < 2; m++) begin
        m_cnt[m][c] = 0;
        m_ovf[m][c] = 1'b0;
        m_hit[m][c] = 1'b0;
      end
    end
  endtask

  // Called at a rising edge with the inputs that edge sees.
  task automatic model_edge();
    int  sel;
    bit  ev, inc, rc;
    st_t st;
    rd_t r;
    sel = int'(rd_ch);
    if (rd_req) begin
      r = '0;
      if (sel < NCH) begin
        r.dw = W'(m_cnt[0][sel]);
        r.ds = W'(m_cnt[1][sel]);
      end
      rdq.push_back(r);
    end
    for (int c = 0; c < NCH; c++) begin
      for (int k = 3; k > 0; k--) hist[c][k] = hist[c][k-1];
      hist[c][0] = event_in[c];
      // A rise is seen two edges after it is first sampled.
      ev  = hist[c][2] && !hist[c][3];
      inc = ev && !hold[c];
      rc  = rd_req && rd_clr && (sel == c);
      for (int m = 0; m < 2; m++) begin
        m_hit[m][c] = 1'b0;
        if (clear[c]) begin
          m_cnt[m][c] = 0;
          m_ovf[m][c] = 1'b0;
        end else if (rc) begin
          m_cnt[m][c] = inc ? 1 : 0;
          m_ovf[m][c] = 1'b0;
          m_hit[m][c] = inc && (threshold == 1);
        end else if (inc) begin
          if (m_cnt[m][c] == MAXC) m_ovf[m][c] = 1'b1;
          if (!(m == 1 && m_cnt[m][c] == MAXC)) begin
            m_cnt[m][c] = (m_cnt[m][c] + 1) % (MAXC + 1);
            m_hit[m][c] = (m_cnt[m][c] == int'(threshold));
          end
        end
      end
    end
    st = '0;
    for (int c = 0; c < NCH; c++) begin
      st.cw[c*W +: W] = W'(m_cnt[0][c]);
      st.cs[c*W +: W] = W'(m_cnt[1][c]);
      st.ow[c] = m_ovf[0][c];
      st.os[c] = m_ovf[1][c];
      st.hw[c] = m_hit[0][c];
      st.hs[c] = m_hit[1][c];
    end
    stq.push_back(st);
  endtask

  // Returns at the falling edge, ready for the next input change.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    st_t e;
    rd_t r;
    #1;
    if (stq.size() > 0) begin
      e = stq.pop_front();
      check("count_wrap", 32'(count_w), 32'(e.cw));
      check("count_sat",  32'(count_s), 32'(e.cs));
      check("ovf_wrap",   32'(ovf_w),   32'(e.ow));
      check("ovf_sat",    32'(ovf_s),   32'(e.os));
      check("hit_wrap",   32'(hit_w),   32'(e.hw));
      check("hit_sat",    32'(hit_s),   32'(e.hs));
    end
    if (rdq.size() > 0 || rdv_w || rdv_s) begin
      check("rd_valid_wrap", 32'(rdv_w), 32'(rdq.size() > 0));
      check("rd_valid_sat",  32'(rdv_s), 32'(rdq.size() > 0));
      if (rdq.size() > 0) begin
        r = rdq.pop_front();
        check("rd_data_wrap", 32'(rdd_w), 32'(r.dw));
        check("rd_data_sat",  32'(rdd_s), 32'(r.ds));
      end
    end
  end

  task automatic randomize_inputs(input bit allow_clear);
    for (int c = 0; c < NCH; c++) begin
      if ($urandom_range(2) == 0) event_in[c] = ~event_in[c];
      hold[c]  = ($urandom_range(3) == 0);
      clear[c] = allow_clear && ($urandom_range(63) == 0);
    end
    if ($urandom_range(49) == 0) threshold = W'($urandom_range(MAXC));
    rd_req = ($urandom_range(2) == 0);
    rd_clr = allow_clear && ($urandom_range(3) == 0);
    rd_ch  = 2'($urandom_range(3));
  endtask

  initial begin
    rst       = 1'b1;
    event_in  = '1;
    hold      = '0;
    clear     = '0;
    threshold = 4'd3;
    rd_req    = 1'b0;
    rd_clr    = 1'b0;
    rd_ch     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_count_wrap", 32'(count_w), 0);
    check("rst_count_sat",  32'(count_s), 0);
    check("rst_ovf",        32'({ovf_w, ovf_s}), 0);
    check("rst_hit",        32'({hit_w, hit_s}), 0);
    check("rst_rd_valid",   32'({rdv_w, rdv_s}), 0);
    check("rst_rd_data",    32'({rdd_w, rdd_s}), 0);

    // Levels high through reset release must not count.
    repeat (8) step();

    // Long stretch without clears so counters wrap and saturate.
    for (int i = 0; i < 1200; i++) begin
      randomize_inputs(1'b0);
      step();
    end

    // Asynchronous reset in the middle of a cycle.
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_count", 32'({count_w, count_s}), 0);
    check("async_rst_ovf",   32'({ovf_w, ovf_s}), 0);
    check("async_rst_rdv",   32'({rdv_w, rdv_s}), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    for (int i = 0; i < 1800; i++) begin
      randomize_inputs(1'b1);
      step();
    end

    rd_req = 1'b0;
    rd_clr = 1'b0;
    clear  = '0;
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
